// File: rtl/verlet_step_pkg.sv
// Shared types, FSM states and default world-box bounds for the particle pipeline
// (verlet_step, node and constraint stages).
package sim_pkg;

    localparam int POS_W = 16;

    typedef logic signed [POS_W-1:0] pos_t;
    typedef logic signed [POS_W+1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CLAMP = 2'd2,
        OUT   = 2'd3
    } step_state_t;

    localparam pos_t DEF_X_MIN = 16'sh0000;
    localparam pos_t DEF_X_MAX = 16'sh7F00;
    localparam pos_t DEF_Y_MIN = 16'sh0000;
    localparam pos_t DEF_Y_MAX = 16'sh7F00;

endpackage

// File: rtl/verlet_step_clamp_axis.sv
// Saturates one wide position axis to [MIN, MAX]; hit flags that the wall was touched.
import sim_pkg::*;

module clamp_axis #(
    parameter pos_t MIN = DEF_X_MIN,
    parameter pos_t MAX = DEF_X_MAX
) (
    input  wide_t raw,
    output pos_t  clamped,
    output logic  hit
);

    always_comb begin
        clamped = raw[POS_W-1:0];
        hit     = 1'b0;
        if (raw < wide_t'(MIN)) begin
            clamped = MIN;
            hit     = 1'b1;
        end else if (raw > wide_t'(MAX)) begin
            clamped = MAX;
            hit     = 1'b1;
        end
    end

endmodule

// File: rtl/verlet_step.sv
// Single-particle Verlet integrator with world-box clamping and valid/ready output.
// Optional velocity damping is enabled by defining VERLET_DAMPING_EN.
import sim_pkg::*;

module verlet_step #(
    parameter int         W          = POS_W,
    parameter logic signed [W-1:0] X_MIN = DEF_X_MIN,
    parameter logic signed [W-1:0] X_MAX = DEF_X_MAX,
    parameter logic signed [W-1:0] Y_MIN = DEF_Y_MIN,
    parameter logic signed [W-1:0] Y_MAX = DEF_Y_MAX,
    parameter int         DAMP_SHIFT = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_valid,
    input  logic [W-1:0] init_x,
    input  logic [W-1:0] init_y,
    input  logic         step_valid,
    output logic         step_ready,
    input  logic [W-1:0] ax,
    input  logic [W-1:0] ay,
    input  logic         pin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic [W-1:0] out_vx,
    output logic [W-1:0] out_vy
);

`ifdef VERLET_DAMPING_EN
    localparam bit DAMP_ON = 1'b1;
`else
    localparam bit DAMP_ON = 1'b0;
`endif

    step_state_t state, next_state;

    pos_t  x, y, px, py;
    pos_t  ax_l, ay_l;
    logic  pin_l;
    wide_t raw_x, raw_y;
    wide_t vel_x, vel_y, damp_x, damp_y, sum_x, sum_y;
    pos_t  clamp_x, clamp_y;
    logic  hit_x, hit_y;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        step_ready = 1'b0;
        case (state)
            IDLE: begin
                step_ready = !init_valid;
                if (!init_valid && step_valid) next_state = CALC;
            end
            CALC:  next_state = CLAMP;
            CLAMP: next_state = OUT;
            OUT:   if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With damping off the shift term folds to zero and no logic remains.
    always_comb begin
        vel_x  = wide_t'(x) - wide_t'(px);
        vel_y  = wide_t'(y) - wide_t'(py);
        damp_x = DAMP_ON ? (vel_x >>> DAMP_SHIFT) : '0;
        damp_y = DAMP_ON ? (vel_y >>> DAMP_SHIFT) : '0;
        sum_x  = wide_t'(x) + (vel_x - damp_x) + wide_t'(ax_l);
        sum_y  = wide_t'(y) + (vel_y - damp_y) + wide_t'(ay_l);
    end

    clamp_axis #(.MIN(X_MIN), .MAX(X_MAX)) u_clamp_x (
        .raw(raw_x), .clamped(clamp_x), .hit(hit_x)
    );

    clamp_axis #(.MIN(Y_MIN), .MAX(Y_MAX)) u_clamp_y (
        .raw(raw_y), .clamped(clamp_y), .hit(hit_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0; y <= '0; px <= '0; py <= '0;
            ax_l <= '0; ay_l <= '0; pin_l <= 1'b0;
            raw_x <= '0; raw_y <= '0;
            out_valid <= 1'b0;
            out_x <= '0; out_y <= '0; out_vx <= '0; out_vy <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_valid) begin
                        x  <= pos_t'(init_x);
                        px <= pos_t'(init_x);
                        y  <= pos_t'(init_y);
                        py <= pos_t'(init_y);
                    end else if (step_valid) begin
                        ax_l  <= pos_t'(ax);
                        ay_l  <= pos_t'(ay);
                        pin_l <= pin;
                    end
                end
                CALC: begin
                    raw_x <= sum_x;
                    raw_y <= sum_y;
                end
                // A wall hit pins both cur and prev to the bound so the axis comes to rest.
                CLAMP: begin
                    out_valid <= 1'b1;
                    if (pin_l) begin
                        px <= x;
                        py <= y;
                        out_x <= x;
                        out_y <= y;
                        out_vx <= '0;
                        out_vy <= '0;
                    end else begin
                        x  <= clamp_x;
                        y  <= clamp_y;
                        px <= hit_x ? clamp_x : x;
                        py <= hit_y ? clamp_y : y;
                        out_x  <= clamp_x;
                        out_y  <= clamp_y;
                        out_vx <= hit_x ? '0 : clamp_x - x;
                        out_vy <= hit_y ? '0 : clamp_y - y;
                    end
                end
                OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_verlet_step.sv
// Directed self-checking bench for verlet_step; expected values are hand-computed.
// Damping expectations switch on VERLET_DAMPING_EN.
module tb_verlet_step;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_valid;
    logic [15:0] init_x, init_y;
    logic        step_valid;
    logic        step_ready;
    logic [15:0] ax, ay;
    logic        pin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x, out_y, out_vx, out_vy;

    int tests_run = 0;
    int tests_failed = 0;
    int lat;

    verlet_step dut (
        .clk(clk), .rst(rst),
        .init_valid(init_valid), .init_x(init_x), .init_y(init_y),
        .step_valid(step_valid), .step_ready(step_ready),
        .ax(ax), .ay(ay), .pin(pin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_vx(out_vx), .out_vy(out_vy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!step_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!step_ready) checkOutput("idle_timeout", 16'(step_ready), 16'd1);
    endtask

    task automatic applyInit(input logic [15:0] ix, input logic [15:0] iy);
        waitIdle();
        init_valid = 1'b1; init_x = ix; init_y = iy;
        @(posedge clk); #1;
        init_valid = 1'b0;
    endtask

    // Returns #1 after the edge where out_valid rises; n counts edges after accept.
    task automatic applyStimulus(input logic [15:0] sax, input logic [15:0] say,
                                 input logic spin, output int n);
        waitIdle();
        ax = sax; ay = say; pin = spin; step_valid = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) checkOutput("out_valid_timeout", 16'(out_valid), 16'd1);
    endtask

    initial begin
        rst = 1'b1; init_valid = 1'b0; init_x = '0; init_y = '0;
        step_valid = 1'b0; ax = '0; ay = '0; pin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
        checkOutput("rst_out_x", out_x, 16'h0000);
        checkOutput("rst_out_vy", out_vy, 16'h0000);
        checkOutput("rst_step_ready", 16'(step_ready), 16'd1);

        applyInit(16'h1000, 16'h2000);
        applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
        checkOutput("t1_latency", 16'(lat), 16'd2);
        checkOutput("t1_x", out_x, 16'h1000);
        checkOutput("t1_y", out_y, 16'h2000);
        checkOutput("t1_vx", out_vx, 16'h0000);
        checkOutput("t1_vy", out_vy, 16'h0000);

        applyInit(16'h0000, 16'h2000);
        applyStimulus(16'h0000, 16'hFFF0, 1'b0, lat);
        checkOutput("fall1_y", out_y, 16'h1FF0);
        checkOutput("fall1_vy", out_vy, 16'hFFF0);
        applyStimulus(16'h0000, 16'hFFF0, 1'b0, lat);
`ifdef VERLET_DAMPING_EN
        checkOutput("fall2_y", out_y, 16'h1FD1);
        checkOutput("fall2_vy", out_vy, 16'hFFE1);
`else
        checkOutput("fall2_y", out_y, 16'h1FD0);
        checkOutput("fall2_vy", out_vy, 16'hFFE0);
`endif
        applyStimulus(16'h0000, 16'hFFF0, 1'b0, lat);
`ifdef VERLET_DAMPING_EN
        checkOutput("fall3_y", out_y, 16'h1FA3);
        checkOutput("fall3_vy", out_vy, 16'hFFD2);
`else
        checkOutput("fall3_y", out_y, 16'h1FA0);
        checkOutput("fall3_vy", out_vy, 16'hFFD0);
`endif
        checkOutput("fall3_x", out_x, 16'h0000);

        applyInit(16'h0000, 16'h0010);
        applyStimulus(16'h0000, 16'hFFC0, 1'b0, lat);
        checkOutput("floor_y", out_y, 16'h0000);
        checkOutput("floor_vy", out_vy, 16'h0000);
        applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
        checkOutput("floor_rest_y", out_y, 16'h0000);
        checkOutput("floor_rest_vy", out_vy, 16'h0000);

        applyInit(16'h7EF0, 16'h0000);
        applyStimulus(16'h0040, 16'h0000, 1'b0, lat);
        checkOutput("wall_x", out_x, 16'h7F00);
        checkOutput("wall_vx", out_vx, 16'h0000);
        checkOutput("wall_y", out_y, 16'h0000);
        applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
        checkOutput("wall_rest_x", out_x, 16'h7F00);
        checkOutput("wall_rest_vx", out_vx, 16'h0000);

        applyInit(16'h0000, 16'h0000);
        applyStimulus(16'h0100, 16'h0000, 1'b0, lat);
        checkOutput("prepin_x", out_x, 16'h0100);
        checkOutput("prepin_vx", out_vx, 16'h0100);
        applyStimulus(16'h0050, 16'h0000, 1'b1, lat);
        checkOutput("pin_x", out_x, 16'h0100);
        checkOutput("pin_vx", out_vx, 16'h0000);
        checkOutput("pin_vy", out_vy, 16'h0000);
        applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
        checkOutput("postpin_x", out_x, 16'h0100);
        checkOutput("postpin_vx", out_vx, 16'h0000);

        applyInit(16'h0400, 16'h0400);
        out_ready = 1'b0;
        applyStimulus(16'h0010, 16'h0000, 1'b0, lat);
        step_valid = 1'b1; init_valid = 1'b1; init_x = 16'h5000; init_y = 16'h5000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", 16'(out_valid), 16'd1);
            checkOutput("hold_x", out_x, 16'h0410);
            checkOutput("hold_vx", out_vx, 16'h0010);
            checkOutput("hold_ready", 16'(step_ready), 16'd0);
        end
        step_valid = 1'b0; init_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("hold_release", 16'(out_valid), 16'd0);
        applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
        checkOutput("after_hold_x", out_x, 16'h0420);
        checkOutput("after_hold_y", out_y, 16'h0400);

        waitIdle();
        ax = 16'h0000; ay = 16'h0000; pin = 1'b0; step_valid = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0; init_valid = 1'b1; init_x = 16'h5000; init_y = 16'h5000;
        @(posedge clk); #1;
        init_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("calc_init_valid", 16'(out_valid), 16'd1);
        checkOutput("calc_init_x", out_x, 16'h0430);
        checkOutput("calc_init_vx", out_vx, 16'h0010);

        waitIdle();
        init_valid = 1'b1; init_x = 16'h0200; init_y = 16'h0300;
        step_valid = 1'b1; ax = 16'h0040; ay = 16'h0040;
        #1 checkOutput("both_ready", 16'(step_ready), 16'd0);
        @(posedge clk); #1;
        init_valid = 1'b0; step_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("both_no_step", 16'(out_valid), 16'd0);
        @(posedge clk); #1;
        checkOutput("both_no_step2", 16'(out_valid), 16'd0);
        applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
        checkOutput("both_x", out_x, 16'h0200);
        checkOutput("both_y", out_y, 16'h0300);
        checkOutput("both_vx", out_vx, 16'h0000);

        applyInit(16'h0000, 16'h0000);
        applyStimulus(16'h0100, 16'h0000, 1'b0, lat);
        checkOutput("damp1_x", out_x, 16'h0100);
        checkOutput("damp1_vx", out_vx, 16'h0100);
        applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
`ifdef VERLET_DAMPING_EN
        checkOutput("damp2_x", out_x, 16'h01FC);
        checkOutput("damp2_vx", out_vx, 16'h00FC);
`else
        checkOutput("damp2_x", out_x, 16'h0200);
        checkOutput("damp2_vx", out_vx, 16'h0100);
`endif

        waitIdle();
        ax = 16'h0100; ay = 16'h0100; step_valid = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort_valid", 16'(out_valid), 16'd0);
        checkOutput("abort_x", out_x, 16'h0000);
        checkOutput("abort_ready", 16'(step_ready), 16'd1);
        applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
        checkOutput("abort_pos_x", out_x, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/verlet_step.md
Name: verlet_step

Overview:
- Upstream integration stage for the per-particle `node` block.
- Holds one particle's current and previous fixed-point position (x, y).
- On each accepted step, computes the Verlet update: new = 2*cur − prev + a*dt².
- Clamps the result to the world box and presents new position and velocity to downstream nodes and constraint stages over a valid/ready handshake.

Parameters:
- W, 16, position/accel width; signed Q8.8 two's complement.
- X_MIN, 0, left wall (signed, W bits).
- X_MAX, 16'sh7F00, right wall; X_MIN <= X_MAX required.
- Y_MIN, 0, floor.
- Y_MAX, 16'sh7F00, ceiling; Y_MIN <= Y_MAX required.
- DAMP_SHIFT, 6, damping divisor exponent; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high (decided: one clock, synchronous active-high reset).
- init_valid  in  1  load position; acted on only in IDLE.
- init_x  in  W  initial x.
- init_y  in  W  initial y.
- step_valid  in  1  request one integration step.
- step_ready  out  1  step accepted when step_valid & step_ready.
- ax  in  W  x acceleration pre-scaled by dt², Q8.8.
- ay  in  W  y acceleration pre-scaled by dt², Q8.8.
- pin  in  1  particle fixed for this step; sampled with the step.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_x  out  W  committed x.
- out_y  out  W  committed y.
- out_vx  out  W  out_x − prev_x.
- out_vy  out  W  out_y − prev_y.

Behaviour:
- Reset: x, y, px, py = 0; state IDLE; out_valid = 0; out_x/out_y/out_vx/out_vy = 0. Reset mid-operation aborts the step; no commit occurs.
- FSM transitions:
  - IDLE: if init_valid, load x=px=init_x and y=py=init_y; stay IDLE; outputs unchanged; no out_valid. Otherwise, if step_valid, latch ax, ay, pin and go to CALC.
  - CALC: compute raw_x = x + (x − px) + ax in W+2 bits (same for y); go to CLAMP.
  - CLAMP: saturate each axis to [MIN, MAX], commit, update outputs, set out_valid=1, go to OUT.
  - OUT: hold out_valid and all outputs stable until out_ready, then go to IDLE (out_valid=0).
- step_ready = (state==IDLE) && !init_valid. Init has priority over step in the same cycle; init in any other state is ignored.
- Latency: step accepted on edge t; out_valid high after edge t+2. Earliest next accept is the cycle after the out_ready handshake, giving a minimum of 4 cycles per step.
- Commit:
  - Normal: px <= x, x <= clamped.
  - Clamped axis (raw outside bounds): x <= bound, px <= bound, so velocity on that axis is 0 (inelastic wall).
  - pin=1: x, y unchanged; px <= x, py <= y; velocity 0; ax/ay ignored.
- Arithmetic:
  - All signed. Intermediate values are W+2 bits, so no wrap.
  - Clamping to bounds guarantees the committed value fits W bits.
  - out_v = committed − committed_prev, W bits.
- Per-axis clamping is independent: an x wall hit does not affect y.

Optional Feature:
- Macro: VERLET_DAMPING_EN.
- Defined: v = x − px is replaced by v − (v >>> DAMP_SHIFT) (arithmetic shift) before adding, in CALC. Applies per axis; no extra latency.
- Undefined: pure Verlet, no damping logic synthesized.

Decomposition:
- Package sim_pkg:
  - POS_W localparam.
  - pos_t signed typedef.
  - wide_t (POS_W+2) typedef.
  - step_state_t enum {IDLE, CALC, CLAMP, OUT}.
  - Default bound constants, shared with node and constraint stages.
- Sub-module clamp_axis: wide_t in, MIN/MAX parameters → pos_t out plus hit flag; purely combinational, instantiated for x and y.

Test Plan:
- Reset, init (0x1000, 0x2000), step ax=ay=0 → out_valid exactly 2 cycles after accept; out = (0x1000, 0x2000); v = (0, 0).
- Init y=0x2000, three steps with ay=−16 (0xFFF0), out_ready=1 → y = 0x1FF0, 0x1FD0, 0x1FA0; vy = −16, −32, −48.
- Init y=0x0010, step ay=−0x40 → y=0, vy=0 (floor clamp). Then step ay=0 → y stays 0, vy=0. Init x=0x7EF0, ax=+0x40 → x=0x7F00, vx=0.
- After a step producing vx=0x0100, step with pin=1, ax=0x50 → out_x unchanged, vx=0, vy=0.
- Hold out_ready=0 for 5 cycles → out_valid and data stable, step_ready=0, step_valid and init_valid ignored. Init during CALC leaves position unchanged. Init and step both asserted in IDLE → init taken, step_ready=0 that cycle.
- With VERLET_DAMPING_EN, DAMP_SHIFT=6: init x=0, step ax=0x100 (x=0x100, vx=0x100), then step ax=0 → x=0x1FC, vx=0xFC. Same sequence without the macro → x=0x200, vx=0x100.
